// File: rtl/collision_monitor.sv
// collision_monitor: filtered player/obstacle collision detection with
// respawn freeze, obstacle restart pulse and a saturating death count.
module collision_monitor #(
    parameter int unsigned X_LO          = 100,
    parameter int unsigned X_HI          = 130,
    parameter int unsigned CLEAR_HEIGHT  = 40,
    parameter int unsigned HIT_FILTER    = 2,
    parameter int unsigned RESPAWN_TICKS = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] obj_pos,
    input  logic [9:0] distance,
    input  logic       obstacle_active,
    input  logic       menu,
    input  logic       victory,
    output logic       player_death,
    output logic       freeze,
    output logic       reset_obj,
    output logic [7:0] deaths,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PLAY    = 3'd1,
        HIT     = 3'd2,
        RESPAWN = 3'd3,
        WON     = 3'd4
    } state_t;

    localparam int CW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;

    localparam logic [9:0]    POS_LO    = 10'(X_LO);
    localparam logic [9:0]    POS_HI    = 10'(X_HI);
    localparam logic [9:0]    CLEAR     = 10'(CLEAR_HEIGHT);
    localparam logic [3:0]    FILT_LAST = 4'(HIT_FILTER - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(RESPAWN_TICKS - 1);

    state_t        fsm;
    logic [3:0]    filt;
    logic [CW-1:0] cool;
    logic          overlap;
    logic          hit_now;

    assign overlap = obstacle_active
                   && (obj_pos >= POS_LO)
                   && (obj_pos <= POS_HI)
                   && (distance < CLEAR);

    assign hit_now = overlap && (filt == FILT_LAST);
    assign state   = fsm;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm          <= IDLE;
            filt         <= '0;
            cool         <= '0;
            deaths       <= '0;
            player_death <= 1'b0;
            freeze       <= 1'b0;
            reset_obj    <= 1'b0;
        end else begin
            player_death <= 1'b0;
            freeze       <= 1'b0;
            reset_obj    <= 1'b0;

            // Saturating run length of consecutive overlap cycles in PLAY
            if (fsm == PLAY && overlap)
                filt <= (filt == 4'hF) ? filt : filt + 4'd1;
            else
                filt <= '0;

            unique case (fsm)
                IDLE: begin
                    if (!menu) begin
                        fsm       <= PLAY;
                        deaths    <= '0;
                        reset_obj <= 1'b1;
                    end
                end
                PLAY: begin
                    if (menu) begin
                        fsm <= IDLE;
                    end else if (victory) begin
                        fsm <= WON;
                    end else if (hit_now) begin
                        fsm          <= HIT;
                        player_death <= 1'b1;
                    end
                end
                HIT: begin
                    if (deaths != 8'hFF)
                        deaths <= deaths + 8'd1;
                    if (menu) begin
                        fsm <= IDLE;
                    end else begin
                        fsm    <= RESPAWN;
                        cool   <= COOL_LOAD;
                        freeze <= 1'b1;
                    end
                end
                RESPAWN: begin
                    if (menu) begin
                        fsm <= IDLE;
                    end else if (cool == '0) begin
                        fsm       <= PLAY;
                        reset_obj <= 1'b1;
                    end else begin
                        cool   <= cool - 1'b1;
                        freeze <= 1'b1;
                    end
                end
                WON: begin
                    if (menu)
                        fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor: cycle scoreboard against a behavioural model,
// plus directed checks for the collision, respawn and saturation cases.
module tb_collision_monitor;

    logic       clk;
    logic       reset_n;
    logic [9:0] obj_pos;
    logic [9:0] distance;
    logic       obstacle_active;
    logic       menu;
    logic       victory;
    logic       player_death;
    logic       freeze;
    logic       reset_obj;
    logic [7:0] deaths;
    logic [2:0] state;

    collision_monitor dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .obj_pos         (obj_pos),
        .distance        (distance),
        .obstacle_active (obstacle_active),
        .menu            (menu),
        .victory         (victory),
        .player_death    (player_death),
        .freeze          (freeze),
        .reset_obj       (reset_obj),
        .deaths          (deaths),
        .state           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pd;
        logic       frz;
        logic       ro;
        logic [7:0] dth;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;
    int pd_cnt = 0;
    int fz_cnt = 0;

    // Model: 0 IDLE, 1 PLAY, 2 HIT, 3 RESPAWN, 4 WON
    logic [2:0] m_st     = 3'd0;
    int         m_run    = 0;
    int         m_left   = 0;
    logic [7:0] m_deaths = 8'd0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_step();
        exp_t e;
        bit   ov;
        ov = obstacle_active && (obj_pos >= 10'd100) && (obj_pos <= 10'd130)
             && (distance < 10'd40);
        e.pd  = 1'b0;
        e.frz = 1'b0;
        e.ro  = 1'b0;
        if (!reset_n) begin
            m_st     = 3'd0;
            m_run    = 0;
            m_left   = 0;
            m_deaths = 8'd0;
        end else begin
            case (m_st)
                3'd0: if (!menu) begin
                    m_st     = 3'd1;
                    m_deaths = 8'd0;
                    m_run    = 0;
                    e.ro     = 1'b1;
                end
                3'd1: begin
                    if (menu) m_st = 3'd0;
                    else if (victory) m_st = 3'd4;
                    else if (ov && (m_run + 1 == 2)) begin
                        m_st = 3'd2;
                        e.pd = 1'b1;
                    end
                    if (m_st == 3'd1) m_run = ov ? m_run + 1 : 0;
                    else m_run = 0;
                end
                3'd2: begin
                    if (m_deaths != 8'd255) m_deaths = m_deaths + 8'd1;
                    if (menu) m_st = 3'd0;
                    else begin
                        m_st   = 3'd3;
                        m_left = 24;
                        e.frz  = 1'b1;
                    end
                end
                3'd3: begin
                    if (menu) m_st = 3'd0;
                    else if (m_left == 1) begin
                        m_st  = 3'd1;
                        m_run = 0;
                        e.ro  = 1'b1;
                    end else begin
                        m_left = m_left - 1;
                        e.frz  = 1'b1;
                    end
                end
                3'd4: if (menu) m_st = 3'd0;
                default: m_st = 3'd0;
            endcase
        end
        e.st  = m_st;
        e.dth = m_deaths;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_death",  int'(player_death), int'(e.pd));
        check("sb_freeze", int'(freeze),       int'(e.frz));
        check("sb_rstobj", int'(reset_obj),    int'(e.ro));
        check("sb_deaths", int'(deaths),       int'(e.dth));
        check("sb_state",  int'(state),        int'(e.st));
        if (player_death) pd_cnt++;
        if (freeze) fz_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset_n         = 1'b0;
        menu            = 1'b0;
        victory         = 1'b0;
        obj_pos         = 10'd110;
        distance        = 10'd10;
        obstacle_active = 1'b1;
        ticks(2);
        check("rst_state",  int'(state),        0);
        check("rst_death",  int'(player_death), 0);
        check("rst_freeze", int'(freeze),       0);
        check("rst_rstobj", int'(reset_obj),    0);
        check("rst_deaths", int'(deaths),       0);

        // 1: basic hit and respawn
        reset_n = 1'b1;
        tick();
        check("s1_enter_ro", int'(reset_obj), 1);
        check("s1_enter_st", int'(state), 1);
        tick();
        check("s1_nodeath", int'(player_death), 0);
        tick();
        check("s1_death", int'(player_death), 1);
        fz_cnt = 0;
        pd_cnt = 0;
        ticks(24);
        check("s1_frz_len", fz_cnt, 24);
        check("s1_one_pulse", pd_cnt, 0);
        tick();
        check("s1_frz_off", int'(freeze), 0);
        check("s1_resp_ro", int'(reset_obj), 1);
        check("s1_deaths", int'(deaths), 1);
        tick();
        check("s1_refilter", int'(state), 1);
        obstacle_active = 1'b0;
        tick();

        // 2: clearing heights and column edges
        pd_cnt          = 0;
        obstacle_active = 1'b1;
        distance        = 10'd40;
        obj_pos         = 10'd100;
        ticks(4);
        obj_pos = 10'd130;
        ticks(4);
        distance = 10'd10;
        obj_pos  = 10'd99;
        ticks(4);
        obj_pos = 10'd131;
        ticks(4);
        obj_pos         = 10'd110;
        obstacle_active = 1'b0;
        ticks(4);
        check("s2_clear", pd_cnt, 0);
        obstacle_active = 1'b1;
        obj_pos         = 10'd130;
        distance        = 10'd39;
        ticks(2);
        check("s2_edge_hit", int'(player_death), 1);
        obstacle_active = 1'b0;
        ticks(25);
        check("s2_back", int'(state), 1);

        // 3: filter glitch
        pd_cnt = 0;
        obj_pos  = 10'd110;
        distance = 10'd10;
        obstacle_active = 1'b1; tick();
        obstacle_active = 1'b0; tick();
        obstacle_active = 1'b1; tick();
        obstacle_active = 1'b0; tick();
        check("s3_glitch", pd_cnt, 0);
        obstacle_active = 1'b1;
        ticks(2);
        obstacle_active = 1'b0;
        check("s3_hit", int'(player_death), 1);
        ticks(25);
        check("s3_once", pd_cnt, 1);

        // 4: overlap and victory together
        pd_cnt = 0;
        obstacle_active = 1'b1;
        tick();
        victory = 1'b1;
        tick();
        check("s4_won", int'(state), 4);
        ticks(5);
        check("s4_nodeath", pd_cnt, 0);
        check("s4_deaths", int'(deaths), 3);
        victory         = 1'b0;
        obstacle_active = 1'b0;
        menu            = 1'b1;
        tick();
        check("s4_idle", int'(state), 0);
        check("s4_hold", int'(deaths), 3);

        // 5: abort by menu and by reset mid-respawn
        menu            = 1'b0;
        obstacle_active = 1'b1;
        ticks(3);
        check("s5_hit", int'(state), 2);
        ticks(5);
        check("s5_resp", int'(freeze), 1);
        menu = 1'b1;
        tick();
        check("s5_ab_st", int'(state), 0);
        check("s5_ab_frz", int'(freeze), 0);
        check("s5_ab_ro", int'(reset_obj), 0);
        tick();
        check("s5_ab_ro2", int'(reset_obj), 0);
        menu = 1'b0;
        ticks(8);
        check("s5_resp2", int'(state), 3);
        reset_n = 1'b0;
        tick();
        check("s5_rst_st", int'(state), 0);
        check("s5_rst_frz", int'(freeze), 0);
        check("s5_rst_ro", int'(reset_obj), 0);
        check("s5_rst_pd", int'(player_death), 0);
        check("s5_rst_dth", int'(deaths), 0);

        // 6: death count saturation
        reset_n = 1'b1;
        pd_cnt  = 0;
        for (int i = 0; i < 256 * 30 && pd_cnt < 256; i++) tick();
        check("s6_pulses", pd_cnt, 256);
        tick();
        check("s6_sat", int'(deaths), 255);
        ticks(60);
        check("s6_hold", int'(deaths), 255);
        menu = 1'b1;
        tick();
        check("s6_idle", int'(state), 0);
        menu = 1'b0;
        tick();
        check("s6_clear", int'(deaths), 0);
        check("s6_ro", int'(reset_obj), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
